tile_config_mem: RTL and testbench



---
 rtl/tile_config_mem.sv | 98 +++++++++
 tb/tb_tile_config_mem.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_config_mem.sv
// Configuration memory for a CGRA vector tile: one-shot capture of a full
// configuration vector through a ready/ack handshake, gated read-out to the datapath.
module tile_config_mem #(
  parameter int unsigned width      = 16,
  parameter int unsigned num_regs   = 16,
  parameter int unsigned num_inputs = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             on_off,
  input  logic             write_en,
  output logic             write_rdy,
  input  logic [width-1:0] w_data_in [num_inputs:0],
  output logic             write_ack,
  output logic [width-1:0] r_data_out [num_inputs:0],
  output logic             on_off_vector_fu
);

  localparam int unsigned num_words = num_inputs + 1;

  if (num_regs < num_words) begin : g_depth_check
    $error("tile_config_mem: num_regs must be >= num_inputs+1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             commit_c;
  // Words above num_inputs are never writable and read as zero, so only the
  // writable words are held in flops.
  logic [width-1:0] cfg_q [num_words];

  // Next-state decode; a write is committed only on the IDLE accept edge
  always_comb begin
    state_d  = state_q;
    commit_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (write_en) begin
          state_d  = WRITE;
          commit_c = 1'b1;
        end
      end
      WRITE:   state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register with handshake outputs registered from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      write_rdy <= 1'b1;
      write_ack <= 1'b0;
    end else begin
      state_q   <= state_d;
      write_rdy <= (state_d == IDLE);
      write_ack <= (state_d == ACK);
    end
  end

  // Configuration storage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(num_words); i++) begin
        cfg_q[i] <= '0;
      end
    end else if (commit_c) begin
      for (int i = 0; i < int'(num_words); i++) begin
        cfg_q[i] <= w_data_in[i];
      end
    end
  end

  // Read path samples pre-commit contents when a read and a write share an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(num_words); i++) begin
        r_data_out[i] <= '0;
      end
      on_off_vector_fu <= 1'b0;
    end else begin
      if (on_off) begin
        for (int i = 0; i < int'(num_words); i++) begin
          r_data_out[i] <= cfg_q[i];
        end
      end
      on_off_vector_fu <= on_off;
    end
  end

endmodule

// File: tb/tb_tile_config_mem.sv
// Bench for tile_config_mem: reference model feeds read/ack scoreboards, a
// monitor pops and compares on DUT outputs, plus directed boundary checks.
module tb_tile_config_mem;

  localparam int W  = 16;
  localparam int NR = 16;
  localparam int NI = 8;

  typedef logic [NI:0][W-1:0] vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         on_off;
  logic         write_en;
  logic         write_rdy;
  logic         write_ack;
  logic         on_off_vector_fu;
  logic [W-1:0] w_data_in  [NI:0];
  logic [W-1:0] r_data_out [NI:0];
  vec_t         out_v;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: memory image, remaining busy cycles, expected outputs
  vec_t mem_m   = '0;
  vec_t exp_out = '0;
  int   busy    = 0;
  logic exp_fu  = 1'b0;
  int   cyc     = 0;
  vec_t rd_q [$];
  int   ack_q [$];

  always #5 clk = ~clk;

  tile_config_mem #(
    .width      (W),
    .num_regs   (NR),
    .num_inputs (NI)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .on_off           (on_off),
    .write_en         (write_en),
    .write_rdy        (write_rdy),
    .w_data_in        (w_data_in),
    .write_ack        (write_ack),
    .r_data_out       (r_data_out),
    .on_off_vector_fu (on_off_vector_fu)
  );

  always_comb begin
    for (int i = 0; i <= NI; i++) out_v[i] = r_data_out[i];
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chkv(input string name, input vec_t act, input vec_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a write is taken only when no transaction is in flight and then
  // occupies the block for three edges; reads see the image before this edge.
  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        mem_m   = '0;
        exp_out = '0;
        busy    = 0;
        exp_fu  = 1'b0;
        rd_q.delete();
        ack_q.delete();
      end else begin
        cyc++;
        exp_fu = on_off;
        if (on_off) rd_q.push_back(mem_m);
        if (busy == 0 && write_en) begin
          for (int i = 0; i <= NI; i++) mem_m[i] = w_data_in[i];
          busy = 2;
          ack_q.push_back(cyc + 1);
        end else if (busy > 0) begin
          busy--;
        end
      end
    end
  end

  // Monitor: pops expected responses when the DUT presents them
  initial begin
    logic exp_ack;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        chk1("write_rdy", write_rdy, busy == 0);
        chk1("fu_enable", on_off_vector_fu, exp_fu);
        exp_ack = (ack_q.size() > 0) && (ack_q[0] == cyc);
        chk1("write_ack", write_ack, exp_ack);
        if (ack_q.size() > 0 && ack_q[0] <= cyc) void'(ack_q.pop_front());
        if (on_off_vector_fu) begin
          if (rd_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL read_sb: output presented with no read pending at t=%0t", $time);
          end else begin
            exp_out = rd_q.pop_front();
          end
        end
        chkv("r_data_out", out_v, exp_out);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_data(input vec_t v);
    for (int i = 0; i <= NI; i++) w_data_in[i] = v[i];
  endtask

  // Hold write_en until write_ack is seen, bounded
  task automatic do_write(input vec_t v);
    set_data(v);
    write_en = 1'b1;
    for (int k = 0; k < 8 && write_ack !== 1'b1; k++) tick();
    chk1("ack_seen", write_ack, 1'b1);
    write_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vec_t va;
    vec_t v5;
    reset    = 1'b1;
    on_off   = 1'b0;
    write_en = 1'b0;
    set_data('0);
    tick();
    reset = 1'b0;
    #1;
    chk1("rst_rdy", write_rdy, 1'b1);
    chk1("rst_ack", write_ack, 1'b0);
    chk1("rst_fu", on_off_vector_fu, 1'b0);
    chkv("rst_rdata", out_v, '0);
    tick();

    // Write then read
    for (int i = 0; i <= NI; i++) v[i] = W'(i * 10);
    do_write(v);
    on_off = 1'b1;
    tick();
    on_off = 1'b0;
    chkv("read_back", out_v, v);

    // Handshake with a single-cycle write_en
    for (int i = 0; i <= NI; i++) v[i] = W'($urandom);
    set_data(v);
    write_en = 1'b1;
    tick();
    write_en = 1'b0;
    chk1("hs_rdy_low", write_rdy, 1'b0);
    chk1("hs_ack_early", write_ack, 1'b0);
    tick();
    chk1("hs_ack", write_ack, 1'b1);
    chk1("hs_rdy_busy", write_rdy, 1'b0);
    tick();
    chk1("hs_ack_end", write_ack, 1'b0);
    chk1("hs_rdy_back", write_rdy, 1'b1);

    // Enable pipeline 0 -> 1 -> 0
    on_off = 1'b0;
    tick();
    chk1("en_0", on_off_vector_fu, 1'b0);
    on_off = 1'b1;
    tick();
    chk1("en_1", on_off_vector_fu, 1'b1);
    on_off = 1'b0;
    tick();
    chk1("en_2", on_off_vector_fu, 1'b0);

    // Hold while on_off is low
    va = {(NI + 1){16'hAAAA}};
    v5 = {(NI + 1){16'h5555}};
    do_write(va);
    on_off = 1'b1;
    tick();
    on_off = 1'b0;
    chkv("hold_a", out_v, va);
    tick();
    do_write(v5);
    tick();
    chkv("hold_keep", out_v, va);
    on_off = 1'b1;
    tick();
    on_off = 1'b0;
    chkv("hold_new", out_v, v5);

    // Randomized traffic, including reads on write-commit edges
    repeat (400) begin
      write_en = ($urandom_range(0, 2) == 0);
      on_off   = 1'($urandom_range(0, 1));
      for (int i = 0; i <= NI; i++) w_data_in[i] = W'($urandom);
      tick();
    end
    write_en = 1'b0;
    on_off   = 1'b0;
    repeat (4) tick();

    // Asynchronous reset while in WRITE
    for (int i = 0; i <= NI; i++) v[i] = W'($urandom_range(1, 16'hFFFF));
    set_data(v);
    on_off   = 1'b1;
    write_en = 1'b1;
    @(posedge clk);
    #2;
    reset    = 1'b1;
    write_en = 1'b0;
    on_off   = 1'b0;
    #1;
    chk1("arst_rdy", write_rdy, 1'b1);
    chk1("arst_ack", write_ack, 1'b0);
    chk1("arst_fu", on_off_vector_fu, 1'b0);
    chkv("arst_rdata", out_v, '0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk1("arst_no_ack", write_ack, 1'b0);
      chk1("arst_rdy_hold", write_rdy, 1'b1);
    end
    tick();
    reset = 1'b0;
    tick();
    chk1("post_rst_ack", write_ack, 1'b0);
    on_off = 1'b1;
    tick();
    on_off = 1'b0;
    chkv("storage_cleared", out_v, '0);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
